gpc3103_bist: RTL

- Built-in self-test controller for the gpc3103_5 compressor. Counts 3+0+1+3 input bits at weights 1/4/8 into a 5-bit sum.
- Acts as the stimulus/response end of the GPC input/output interface: sweeps all 128 input vectors into a GPC under test and collects its dst back.
- Compares each dst against an internal reference sum, then reports error count, first failure and pass/fail.
- Sits beside any gpc3103 instance: on FPGA for hardware self-test, or in simulation as a synthesizable checker.

---
 rtl/gpc3103_pkg.sv | 32 +++
 rtl/gpc3103_ref_sum.sv | 16 +
 rtl/gpc3103_bist.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gpc3103_pkg.sv
// Shared constants, FSM states and delay-line entry type for the gpc3103 BIST.
// The weights here define the reference sum that the GPC under test must match.
package gpc3103_pkg;

  localparam int VEC_W   = 7;
  localparam int DST_W   = 5;
  localparam int SRC0_W  = 3;
  localparam int SRC2_W  = 1;
  localparam int SRC3_W  = 3;
  localparam int W0      = 1;
  localparam int W2      = 4;
  localparam int W3      = 8;
  localparam int NUM_VEC = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [VEC_W-1:0] vec;
    logic [DST_W-1:0] exp;
  } line_entry_t;

  function automatic logic [DST_W-1:0] popcnt3(input logic [2:0] bits);
    return DST_W'(bits[0]) + DST_W'(bits[1]) + DST_W'(bits[2]);
  endfunction

endpackage

// File: rtl/gpc3103_ref_sum.sv
// Reference model of the gpc3103_5 compressor: vec {src3,src2,src0} -> weighted sum.
// Purely combinational so it can also serve as a golden model in other benches.
module gpc3103_ref_sum
  import gpc3103_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [DST_W-1:0] exp
);

  always_comb begin
    exp = popcnt3(vec[2:0]) * DST_W'(W0)
        + DST_W'(vec[3])    * DST_W'(W2)
        + popcnt3(vec[6:4]) * DST_W'(W3);
  end

endmodule

// File: rtl/gpc3103_bist.sv
// BIST controller: sweeps all 128 vectors into a GPC under test, compares each
// returned dst against the reference sum after DUT_LATENCY cycles, reports results.
module gpc3103_bist
  import gpc3103_pkg::*;
#(
  parameter int DUT_LATENCY = 0,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [SRC0_W-1:0]   src0,
  output logic [SRC2_W-1:0]   src2,
  output logic [SRC3_W-1:0]   src3,
  input  logic [DST_W-1:0]    dst,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [VEC_W-1:0]    fail_vec,
  output logic [DST_W-1:0]    fail_dst,
  output logic [DST_W-1:0]    fail_exp
);

  localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VEC - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [2:0]        drain_q, drain_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [VEC_W-1:0]  fail_vec_q, fail_vec_d;
  logic [DST_W-1:0]  fail_dst_q, fail_dst_d;
  logic [DST_W-1:0]  fail_exp_q, fail_exp_d;

  logic [DST_W-1:0]  ref_exp;
  line_entry_t       in_entry;
  line_entry_t       tap;

  gpc3103_ref_sum u_ref_sum (
    .vec (vec_q),
    .exp (ref_exp)
  );

  always_comb begin
    in_entry.valid = (state_q == RUN);
    in_entry.vec   = vec_q;
    in_entry.exp   = ref_exp;
  end

  // Delay line aligns each expected value with the GPC's dst; bypassed when combinational.
  if (DUT_LATENCY > 0) begin : g_line
    line_entry_t line_q [DUT_LATENCY];
    line_entry_t line_d [DUT_LATENCY];

    always_comb begin
      line_d[0] = in_entry;
      for (int i = 1; i < DUT_LATENCY; i++) begin
        line_d[i] = line_q[i-1];
      end
    end

    // NOTE: only the valid bits are reset; vec/exp are don't-care while invalid,
    // so leaving them unreset keeps the shift register free of reset fan-out.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DUT_LATENCY; i++) begin
          line_q[i].valid <= 1'b0;
        end
      end else begin
        line_q <= line_d;
      end
    end

    assign tap = line_q[DUT_LATENCY-1];
  end else begin : g_no_line
    assign tap = in_entry;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    drain_d    = drain_q;
    err_d      = err_q;
    fail_vec_d = fail_vec_q;
    fail_dst_d = fail_dst_q;
    fail_exp_d = fail_exp_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          vec_d      = '0;
          err_d      = '0;
          fail_vec_d = '0;
          fail_dst_d = '0;
          fail_exp_d = '0;
        end
      end
      RUN: begin
        vec_d = vec_q + VEC_W'(1);
        if (vec_q == LAST_VEC) begin
          state_d = (DUT_LATENCY > 0) ? DRAIN : DONE;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Tap is never valid in IDLE/DONE, so this cannot collide with the clear above.
    if (tap.valid && (dst != tap.exp)) begin
      err_d = err_q + ERR_W'(1);
      if (err_q == '0) begin
        fail_vec_d = tap.vec;
        fail_dst_d = dst;
        fail_exp_d = tap.exp;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      drain_q    <= '0;
      err_q      <= '0;
      fail_vec_q <= '0;
      fail_dst_q <= '0;
      fail_exp_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      fail_vec_q <= fail_vec_d;
      fail_dst_q <= fail_dst_d;
      fail_exp_q <= fail_exp_d;
    end
  end

  always_comb begin
    src0     = (state_q == RUN) ? vec_q[2:0] : '0;
    src2     = (state_q == RUN) ? vec_q[3:3] : '0;
    src3     = (state_q == RUN) ? vec_q[6:4] : '0;
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    pass     = done && (err_q == '0);
    err_cnt  = err_q;
    fail_vec = fail_vec_q;
    fail_dst = fail_dst_q;
    fail_exp = fail_exp_q;
  end

endmodule
